// File: rtl/execute_bru_redirect_ctrl.sv
// Front-end redirect sequencer: holds the oldest BRU mispredict until its delay slot
// commits, then issues one redirect to fetch over a valid/ready handshake.
module execute_bru_redirect_ctrl #(
    parameter int unsigned ROB_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_target,
    input  logic             i_taken,
    input  logic             i_pred_taken,
    input  logic [31:0]      i_pred_target,
    input  logic [ROB_W:0]   i_tag,
    input  logic             i_commit_valid,
    input  logic [ROB_W:0]   i_commit_tag,
    input  logic             i_flush,
    output logic             o_redirect_valid,
    input  logic             i_redirect_ready,
    output logic [31:0]      o_redirect_pc,
    output logic             o_pending,
    output logic [31:0]      o_mispredict_count
);

    localparam int unsigned TagW = ROB_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StIssue
    } state_e;

    state_e            state_q, state_d;
    logic [TagW-1:0]   pend_tag_q, pend_tag_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic [31:0]       count_q, count_d;

    logic              mis;
    logic              accept;
    logic              handshake;
    logic              commit_hit;
    logic [31:0]       new_pc;
    logic [TagW-1:0]   ds_tag;

    // Phase bit flips the sense of the index compare across a ROB wrap.
    function automatic logic older(input logic [TagW-1:0] a, input logic [TagW-1:0] b);
        return (a[ROB_W-1:0] < b[ROB_W-1:0]) ^ (a[ROB_W] != b[ROB_W]);
    endfunction

    assign mis        = (i_taken != i_pred_taken) | (i_taken & (i_target != i_pred_target));
    assign accept     = i_valid & o_ready;
    assign new_pc     = i_taken ? i_target : (i_pc + 32'd8);
    assign ds_tag     = pend_tag_q + TagW'(1);
    assign commit_hit = i_commit_valid & (i_commit_tag == ds_tag);
    assign handshake  = (state_q == StIssue) & i_redirect_ready;

    always_comb begin
        state_d    = state_q;
        pend_tag_d = pend_tag_q;
        pend_pc_d  = pend_pc_q;
        count_d    = count_q + {31'd0, handshake};

        if (i_flush) begin
            state_d    = StIdle;
            pend_tag_d = '0;
            pend_pc_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept && mis) begin
                        state_d    = StHold;
                        pend_tag_d = i_tag;
                        pend_pc_d  = new_pc;
                    end
                end
                StHold: begin
                    // A matching commit wins over a same-cycle older replacement.
                    if (commit_hit) begin
                        state_d = StIssue;
                    end else if (accept && mis && older(i_tag, pend_tag_q)) begin
                        pend_tag_d = i_tag;
                        pend_pc_d  = new_pc;
                    end
                end
                StIssue: begin
                    if (handshake) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pend_tag_q <= '0;
            pend_pc_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_tag_q <= pend_tag_d;
            pend_pc_q  <= pend_pc_d;
            count_q    <= count_d;
        end
    end

    assign o_ready            = (state_q != StIssue);
    assign o_redirect_valid   = (state_q == StIssue);
    assign o_redirect_pc      = pend_pc_q;
    assign o_pending          = (state_q != StIdle);
    assign o_mispredict_count = count_q;

endmodule

// File: tb/tb_execute_bru_redirect_ctrl.sv
// Directed table-driven bench for execute_bru_redirect_ctrl plus hand-written corner sequences.
module tb_execute_bru_redirect_ctrl;

    localparam int unsigned ROB_W = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic          o_ready;
    logic [31:0]   i_pc;
    logic [31:0]   i_target;
    logic          i_taken;
    logic          i_pred_taken;
    logic [31:0]   i_pred_target;
    logic [ROB_W:0] i_tag;
    logic          i_commit_valid;
    logic [ROB_W:0] i_commit_tag;
    logic          i_flush;
    logic          o_redirect_valid;
    logic          i_redirect_ready;
    logic [31:0]   o_redirect_pc;
    logic          o_pending;
    logic [31:0]   o_mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    execute_bru_redirect_ctrl #(.ROB_W(ROB_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_pc               (i_pc),
        .i_target           (i_target),
        .i_taken            (i_taken),
        .i_pred_taken       (i_pred_taken),
        .i_pred_target      (i_pred_target),
        .i_tag              (i_tag),
        .i_commit_valid     (i_commit_valid),
        .i_commit_tag       (i_commit_tag),
        .i_flush            (i_flush),
        .o_redirect_valid   (o_redirect_valid),
        .i_redirect_ready   (i_redirect_ready),
        .o_redirect_pc      (o_redirect_pc),
        .o_pending          (o_pending),
        .o_mispredict_count (o_mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           valid;
        logic [31:0]    pc;
        logic [31:0]    target;
        logic           taken;
        logic           pred_taken;
        logic [31:0]    pred_target;
        logic [ROB_W:0] tag;
        logic           cv;
        logic [ROB_W:0] ctag;
        logic           flush;
        logic           rdy;
        logic           e_ready;
        logic           e_rv;
        logic [31:0]    e_pc;
        logic           e_pend;
        logic [31:0]    e_cnt;
    } vec_t;

    vec_t tbl [13];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input vec_t x, input string name);
        chk({name, " ready"}, {31'd0, o_ready}, {31'd0, x.e_ready});
        chk({name, " redirect_valid"}, {31'd0, o_redirect_valid}, {31'd0, x.e_rv});
        chk({name, " pending"}, {31'd0, o_pending}, {31'd0, x.e_pend});
        chk({name, " count"}, o_mispredict_count, x.e_cnt);
        if (x.e_rv) chk({name, " redirect_pc"}, o_redirect_pc, x.e_pc);
    endtask

    task automatic apply(input vec_t x, input string name);
        @(negedge clk);
        i_valid          = x.valid;
        i_pc             = x.pc;
        i_target         = x.target;
        i_taken          = x.taken;
        i_pred_taken     = x.pred_taken;
        i_pred_target    = x.pred_target;
        i_tag            = x.tag;
        i_commit_valid   = x.cv;
        i_commit_tag     = x.ctag;
        i_flush          = x.flush;
        i_redirect_ready = x.rdy;
        @(posedge clk);
        #1;
        check_outs(x, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Inputs: valid pc target taken pred_taken pred_target tag cv ctag flush rdy
        // Expected after edge: ready redirect_valid redirect_pc pending count
        tbl[0]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0,
                    1'b1, 1'b0, 32'h0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 32'h0040_0010, 32'h0, 1'b0, 1'b1, 32'h0, 6'h03, 1'b0, 6'h00, 1'b0, 1'b0,
                    1'b1, 1'b0, 32'h0, 1'b1, 32'd0};
        tbl[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h04, 1'b0, 1'b0,
                    1'b0, 1'b1, 32'h0040_0018, 1'b1, 32'd0};
        tbl[3]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b1,
                    1'b1, 1'b0, 32'h0, 1'b0, 32'd1};
        tbl[4]  = '{1'b1, 32'h0050_0000, 32'h0060_0000, 1'b1, 1'b1, 32'h0060_0000, 6'h05,
                    1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'd1};
        tbl[5]  = '{1'b1, 32'h0040_0ff0, 32'h0040_1000, 1'b1, 1'b1, 32'h0040_0800, 6'h07,
                    1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd1};
        tbl[6]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h07, 1'b0, 1'b0,
                    1'b1, 1'b0, 32'h0, 1'b1, 32'd1};
        tbl[7]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h08, 1'b0, 1'b0,
                    1'b0, 1'b1, 32'h0040_1000, 1'b1, 32'd1};
        tbl[8]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0,
                    1'b0, 1'b1, 32'h0040_1000, 1'b1, 32'd1};
        tbl[9]  = '{1'b1, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 32'h0, 6'h02, 1'b0, 6'h00, 1'b0, 1'b0,
                    1'b0, 1'b1, 32'h0040_1000, 1'b1, 32'd1};
        tbl[10] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0,
                    1'b0, 1'b1, 32'h0040_1000, 1'b1, 32'd1};
        tbl[11] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b1,
                    1'b1, 1'b0, 32'h0, 1'b0, 32'd2};
        tbl[12] = '{1'b1, 32'h0000_0100, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_5678, 6'h09,
                    1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'd2};

        reset = 1'b1;
        i_valid = 1'b0; i_pc = '0; i_target = '0; i_taken = 1'b0; i_pred_taken = 1'b0;
        i_pred_target = '0; i_tag = '0; i_commit_valid = 1'b0; i_commit_tag = '0;
        i_flush = 1'b0; i_redirect_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", {31'd0, o_ready}, 32'd1);
        chk("reset redirect_valid", {31'd0, o_redirect_valid}, 32'd0);
        chk("reset redirect_pc", o_redirect_pc, 32'd0);
        chk("reset pending", {31'd0, o_pending}, 32'd0);
        chk("reset count", o_mispredict_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Replacement across a phase wrap; younger and equal tags dropped.
        v = '{1'b1, 32'h1000, 32'h0, 1'b0, 1'b1, 32'h0, 6'h1E, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd2};
        apply(v, "repl_hold");
        v = '{1'b1, 32'h2000, 32'h0, 1'b0, 1'b1, 32'h0, 6'h21, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd2};
        apply(v, "repl_younger");
        v = '{1'b1, 32'h2800, 32'h0, 1'b0, 1'b1, 32'h0, 6'h1E, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd2};
        apply(v, "repl_equal");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h22, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd2};
        apply(v, "repl_younger_ds");
        v = '{1'b1, 32'h3000, 32'h3400, 1'b1, 1'b0, 32'h0, 6'h1C, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd2};
        apply(v, "repl_older");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h1F, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd2};
        apply(v, "repl_old_ds");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h1D, 1'b0, 1'b0,
              1'b0, 1'b1, 32'h3400, 1'b1, 32'd2};
        apply(v, "repl_issue");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b1,
              1'b1, 1'b0, 32'h0, 1'b0, 32'd3};
        apply(v, "repl_done");

        // Delay-slot tag wrap; commit beats a same-cycle older replacement; flush in ISSUE.
        v = '{1'b1, 32'h4000, 32'h0, 1'b0, 1'b1, 32'h0, 6'h3F, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd3};
        apply(v, "wrap_hold");
        v = '{1'b1, 32'h5000, 32'h0, 1'b0, 1'b1, 32'h0, 6'h3E, 1'b1, 6'h00, 1'b0, 1'b0,
              1'b0, 1'b1, 32'h4008, 1'b1, 32'd3};
        apply(v, "wrap_issue");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b0, 1'b1, 32'h4008, 1'b1, 32'd3};
        apply(v, "wrap_stall");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b0, 32'd3};
        apply(v, "flush_issue_noready");

        // Flush in HOLD, flush in IDLE with an accept, flush with handshake.
        v = '{1'b1, 32'h6000, 32'h0, 1'b0, 1'b1, 32'h0, 6'h02, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd3};
        apply(v, "fl_hold");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h03, 1'b1, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b0, 32'd3};
        apply(v, "fl_hold_flush");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h03, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b0, 32'd3};
        apply(v, "fl_stale_commit");
        v = '{1'b1, 32'h7000, 32'h0, 1'b0, 1'b1, 32'h0, 6'h04, 1'b0, 6'h00, 1'b1, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b0, 32'd3};
        apply(v, "fl_idle_accept");
        v = '{1'b1, 32'h8000, 32'h8800, 1'b1, 1'b1, 32'h8400, 6'h0A, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd3};
        apply(v, "fl_hold2");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h0B, 1'b0, 1'b0,
              1'b0, 1'b1, 32'h8800, 1'b1, 32'd3};
        apply(v, "fl_issue2");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b1,
              1'b1, 1'b0, 32'h0, 1'b0, 32'd4};
        apply(v, "fl_handshake");

        // Minimum latency path then reset in the middle of ISSUE.
        v = '{1'b1, 32'h9000, 32'h0, 1'b0, 1'b1, 32'h0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'd4};
        apply(v, "rst_hold");
        v = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 6'h01, 1'b0, 1'b0,
              1'b0, 1'b1, 32'h9008, 1'b1, 32'd4};
        apply(v, "rst_issue");
        @(negedge clk);
        i_commit_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid redirect_valid", {31'd0, o_redirect_valid}, 32'd0);
        chk("rst_mid pending", {31'd0, o_pending}, 32'd0);
        chk("rst_mid count", o_mispredict_count, 32'd0);
        chk("rst_mid redirect_pc", o_redirect_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_bru_redirect_ctrl.md
Name: execute_bru_redirect_ctrl

Overview:
Sequences front-end redirects from the branch resolution unit. It receives resolved branch results from the BRU and detects mispredictions against the prediction carried with each uop. It holds the oldest outstanding mispredict until its delay slot commits, then issues a single redirect to fetch over a valid/ready handshake. It sits between the BRU execute stage and the fetch redirect port, and a global pipeline flush kills it.

Parameters:
ROB_W, 5, ROB index width; tags are ROB_W+1 bits with the MSB as the wrap phase bit.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
i_valid  input  1  resolved branch result valid
o_ready  output  1  ctrl can accept a result
i_pc  input  32  branch PC
i_target  input  32  computed target from the BRU AGU
i_taken  input  1  resolved direction
i_pred_taken  input  1  predicted direction
i_pred_target  input  32  predicted target
i_tag  input  ROB_W+1  ROB tag of the branch
i_commit_valid  input  1  one instruction committed this cycle
i_commit_tag  input  ROB_W+1  tag of the committed instruction
i_flush  input  1  global pipeline flush
o_redirect_valid  output  1  redirect request to fetch
i_redirect_ready  input  1  fetch accepts redirect
o_redirect_pc  output  32  redirect PC
o_pending  output  1  a mispredict is held or issuing
o_mispredict_count  output  32  completed redirects, wraps at 2^32

Behaviour:
- Reset values: state IDLE, o_redirect_valid=0, o_redirect_pc=0, o_pending=0, o_mispredict_count=0, pending tag/PC=0.
- Mispredict detect: mis = (i_taken != i_pred_taken) | (i_taken & (i_target != i_pred_target)).
- Correct branches are consumed with no state change.
- Redirect PC:
  - taken: i_target.
  - not taken: i_pc+8, the wavefront past the delay slot, 32-bit wrap.
- Accept = i_valid & o_ready. o_ready=1 in IDLE and HOLD, 0 in ISSUE.
- Age compare: older(a,b) = (a[ROB_W-1:0] < b[ROB_W-1:0]) XOR (a[ROB_W] != b[ROB_W]). Equal tags are never older.
- FSM:
  - IDLE: an accepted mis captures tag and redirect PC and moves to HOLD next cycle.
  - HOLD: an accepted mis with older(i_tag, pend_tag) replaces the pending entry. A younger or equal-tag mis is dropped. The delay-slot tag is ds_tag = pend_tag+1 mod 2^(ROB_W+1). If i_commit_valid & i_commit_tag==ds_tag, move to ISSUE next cycle. When a replacement and a matching commit occur in the same cycle, the commit is checked against the old ds_tag; the transition happens and the replacement is dropped.
  - ISSUE: o_redirect_valid=1 and o_redirect_pc is held stable until i_redirect_ready. On the handshake: count+1, go to IDLE next cycle, o_redirect_valid=0 next cycle. There is no combinational path from i_redirect_ready to o_redirect_valid.
- o_pending=1 in HOLD or ISSUE, registered from state.
- Flush (i_flush=1):
  - Highest priority after reset. Next state is IDLE, the pending entry is discarded, and any same-cycle accept is ignored.
  - If a handshake completes in the same cycle as the flush, it counts (count+1).
  - A flush while in IDLE has no effect.
- Reset mid-ISSUE: o_redirect_valid drops the next cycle, and the counter clears.
- Latency: accept to HOLD is 1 cycle. Matching commit to o_redirect_valid is 1 cycle. Minimum accept-to-redirect is 2 cycles.

Test Plan:
- Not-taken mispredict: pc=0x00400010, taken=0, pred_taken=1, tag=3; then commit tag 4 -> redirect_pc=0x00400018 asserted 1 cycle after that commit; ready=1 -> count=1, back to IDLE.
- Target mismatch: taken=1, target=0x00401000, pred_target=0x00400800, tag=7; commit tag 7 gives no redirect; commit tag 8 -> redirect_pc=0x00401000; hold ready=0 for 3 cycles -> valid and pc stable, o_ready=0.
- Replacement with wrap (ROB_W=5): pending tag 0x1E; new mis tag 0x21 (phase flipped, index 1) is younger and dropped; then new mis tag 0x1C is older and replaces -> redirect only after commit tag 0x1D.
- Tag wrap on delay slot: pending tag 0x3F -> ds_tag 0x00; commit 0x00 -> ISSUE.
- Flush in HOLD and in ISSUE: i_flush with ready=0 -> valid=0 next cycle, count unchanged; i_flush together with ready=1 -> count increments, IDLE.
- Correctly predicted branch (taken=1, pred_taken=1, targets equal) -> no state change, o_pending stays 0.
